fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 6 +
 rtl/branch_target.sv | 17 +
 rtl/fetch_stage.sv | 49 ++++
 tb/tb_fetch_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants (PC width, bubble word, opcode width)
package cpu_pkg;
   localparam int          PC_W      = 64;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int          OPCODE_W  = 11;
endpackage

// File: rtl/branch_target.sv
// branch_target: target = pc + (sign-extended word offset << 2)
// ports: pc (IF/ID pc), UncondBr (1 selects BrAddr26 else CondAddr19),
//        BrAddr26/CondAddr19 (signed word offsets), target (byte address)
module branch_target import cpu_pkg::*; #(
   parameter int PC_W = cpu_pkg::PC_W
) (
   input  logic [PC_W-1:0] pc,
   input  logic            UncondBr,
   input  logic [25:0]     BrAddr26,
   input  logic [18:0]     CondAddr19,
   output logic [PC_W-1:0] target
);
   logic [PC_W-1:0] offset;
   assign offset = UncondBr ? {{(PC_W-26){BrAddr26[25]}}, BrAddr26}
                            : {{(PC_W-19){CondAddr19[18]}}, CondAddr19};
   assign target = pc + (offset << 2);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register plus IF/ID pipeline register with one-bubble branch redirect
// ports: clk, reset (sync, active-high), stall (hold PC and IF/ID),
//        BrTaken/UncondBr/BrAddr26/CondAddr19 (ID-stage branch control),
//        imem_addr/imem_data (combinational instruction memory),
//        if_id_instr/if_id_pc/if_id_valid (registered decode inputs)
module fetch_stage import cpu_pkg::*; #(
   parameter int          PC_W      = cpu_pkg::PC_W,
   parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            BrTaken,
   input  logic            UncondBr,
   input  logic [25:0]     BrAddr26,
   input  logic [18:0]     CondAddr19,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_data,
   output logic [31:0]     if_id_instr,
   output logic [PC_W-1:0] if_id_pc,
   output logic            if_id_valid
);
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] target;
   logic            take;
   branch_target #(.PC_W(PC_W)) u_bt (
      .pc(if_id_pc),
      .UncondBr(UncondBr),
      .BrAddr26(BrAddr26),
      .CondAddr19(CondAddr19),
      .target(target)
   );
   // a bubble in IF/ID carries no branch, so it can never redirect
   assign take      = BrTaken & if_id_valid;
   assign imem_addr = pc;
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= '0;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         pc          <= take ? target : pc + PC_W'(4);
         if_id_instr <= take ? NOP_INSTR : imem_data;
         if_id_valid <= !take;
         if_id_pc    <= pc;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table plus randomized checks of fetch_stage against a reference model
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0000;
   logic        clk = 1'b0;
   logic        reset, stall, BrTaken, UncondBr;
   logic [25:0] BrAddr26;
   logic [18:0] CondAddr19;
   logic [63:0] imem_addr, if_id_pc;
   logic [31:0] imem_data, if_id_instr;
   logic        if_id_valid;
   int          tests = 0;
   int          fails = 0;
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_instr;
   logic        m_valid;
   typedef struct {
      logic        r, s, bt, ub;
      logic [25:0] a26;
      logic [18:0] c19;
      logic [63:0] addr, ipc;
      logic        v;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .BrTaken(BrTaken), .UncondBr(UncondBr),
      .BrAddr26(BrAddr26), .CondAddr19(CondAddr19), .imem_addr(imem_addr),
      .imem_data(imem_data), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid)
   );

   function automatic logic [31:0] mem(input logic [63:0] a);
      logic [31:0] w;
      w = a[33:2];
      return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_data = mem(imem_addr);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // reference: one clock edge applied to the architectural state
   task automatic model_edge(input logic r, s, bt, ub, input logic [25:0] a26, input logic [18:0] c19);
      longint off;
      logic [63:0] old_pc;
      old_pc = m_pc;
      off = ub ? longint'($signed(a26)) : longint'($signed(c19));
      if (r) begin
         m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0;
      end else if (!s) begin
         if (bt && m_valid) begin
            m_pc = m_ipc + 64'(off * 4);
            m_instr = NOP; m_valid = 0;
         end else begin
            m_pc = old_pc + 64'd4;
            m_instr = mem(old_pc); m_valid = 1;
         end
         m_ipc = old_pc;
      end
   endtask

   task automatic step(input logic r, s, bt, ub, input logic [25:0] a26, input logic [18:0] c19);
      reset = r; stall = s; BrTaken = bt; UncondBr = ub; BrAddr26 = a26; CondAddr19 = c19;
      @(posedge clk);
      model_edge(r, s, bt, ub, a26, c19);
      #1;
   endtask

   task automatic add(input logic r, s, bt, ub, input logic [25:0] a26, input logic [18:0] c19,
                      input logic [63:0] addr, ipc, input logic v);
      vec_t e;
      e.r = r; e.s = s; e.bt = bt; e.ub = ub; e.a26 = a26; e.c19 = c19;
      e.addr = addr; e.ipc = ipc; e.v = v;
      tbl.push_back(e);
   endtask

   initial begin
      reset = 1; stall = 0; BrTaken = 0; UncondBr = 0; BrAddr26 = 0; CondAddr19 = 0;
      m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0;
      add(1,0,0,0,0,0,         64'h0,   64'h0,   0);
      add(1,0,0,0,0,0,         64'h0,   64'h0,   0);
      add(0,0,0,0,0,0,         64'h4,   64'h0,   1);
      add(0,0,0,0,0,0,         64'h8,   64'h4,   1);
      add(0,0,0,0,0,0,         64'hC,   64'h8,   1);
      add(0,0,1,1,26'd14,0,    64'h40,  64'hC,   0);
      add(0,0,0,0,0,0,         64'h44,  64'h40,  1);
      add(0,0,1,1,26'h3FFFFFE,0, 64'h38, 64'h44, 0);
      add(0,0,1,1,26'h3FFFFFE,0, 64'h3C, 64'h38, 1);
      add(0,0,1,0,0,19'h32,    64'h100, 64'h3C,  0);
      add(0,0,0,0,0,0,         64'h104, 64'h100, 1);
      add(0,0,1,0,0,19'h10,    64'h140, 64'h104, 0);
      add(0,0,0,0,0,0,         64'h144, 64'h140, 1);
      add(0,0,0,0,0,19'h10,    64'h148, 64'h144, 1);
      add(0,0,1,1,26'h3FFFFB7,0, 64'h20, 64'h148, 0);
      add(0,0,0,0,0,0,         64'h24,  64'h20,  1);
      add(0,1,1,1,26'd4,0,     64'h24,  64'h20,  1);
      add(0,1,1,1,26'd4,0,     64'h24,  64'h20,  1);
      add(0,1,1,1,26'd4,0,     64'h24,  64'h20,  1);
      add(0,0,1,1,26'd4,0,     64'h30,  64'h24,  0);
      add(0,0,0,0,0,0,         64'h34,  64'h30,  1);
      add(0,0,1,1,26'h3FFFFF3,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h34, 0);
      add(0,0,0,0,0,0,         64'h0,   64'hFFFF_FFFF_FFFF_FFFC, 1);
      add(0,0,0,0,0,0,         64'h4,   64'h0,   1);
      add(0,0,0,0,0,0,         64'h8,   64'h4,   1);
      add(1,1,1,1,26'd4,0,     64'h0,   64'h0,   0);
      add(0,0,1,1,26'd100,0,   64'h4,   64'h0,   1);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].bt, tbl[i].ub, tbl[i].a26, tbl[i].c19);
         chk($sformatf("vec%0d addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("vec%0d ipc", i), if_id_pc, tbl[i].ipc);
         chk($sformatf("vec%0d valid", i), {63'd0, if_id_valid}, {63'd0, tbl[i].v});
         chk($sformatf("vec%0d instr", i), {32'd0, if_id_instr},
             {32'd0, tbl[i].v ? mem(tbl[i].ipc) : NOP});
      end
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 26'($urandom), 19'($urandom));
         tests++;
         if (imem_addr !== m_pc || if_id_pc !== m_ipc || if_id_instr !== m_instr || if_id_valid !== m_valid) begin
            fails++;
            $display("FAIL rand%0d: got addr=%h ipc=%h instr=%h v=%b want addr=%h ipc=%h instr=%h v=%b",
                     i, imem_addr, if_id_pc, if_id_instr, if_id_valid, m_pc, m_ipc, m_instr, m_valid);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
